// File: rtl/dsp48a1_pkg.sv
// rtl/dsp48a1_pkg.sv - DSP48A1 slice widths and OPMODE field encodings
package dsp48a1_pkg;
    localparam int A_W      = 18;
    localparam int B_W      = 18;
    localparam int D_W      = 18;
    localparam int C_W      = 48;
    localparam int P_W      = 48;
    localparam int OPMODE_W = 8;

    // OPMODE[1:0] selects X, OPMODE[3:2] selects Z
    localparam logic [1:0] X_M           = 2'b01;
    localparam logic [1:0] Z_ZERO        = 2'b00;
    localparam int         PREADD_EN_BIT = 4;
    localparam int         PRESUB_BIT    = 6;
endpackage

// File: rtl/dsp_result_fifo.sv
// rtl/dsp_result_fifo.sv - first-word-fall-through result FIFO, async active-high reset
module dsp_result_fifo #(
    parameter int W     = 53,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The credit counter upstream makes a write into a full FIFO impossible
    assert property (@(posedge clk) disable iff (rst) !(wr_en && full));
endmodule

// File: rtl/dsp48a1_op_sequencer.sv
// rtl/dsp48a1_op_sequencer.sv - launches operand bundles into a DSP48A1 slice and returns tagged results in order
module dsp48a1_op_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int DSP_LAT = 4,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [A_W-1:0]      in_a,
    input  logic [B_W-1:0]      in_b,
    input  logic [D_W-1:0]      in_d,
    input  logic [C_W-1:0]      in_c,
    input  logic [OPMODE_W-1:0] in_opmode,
    input  logic                in_carry_in,
    output logic [A_W-1:0]      dsp_a,
    output logic [B_W-1:0]      dsp_b,
    output logic [D_W-1:0]      dsp_d,
    output logic [C_W-1:0]      dsp_c,
    output logic [OPMODE_W-1:0] dsp_opmode,
    output logic                dsp_carry_in,
    output logic                dsp_ce,
    output logic                dsp_rst,
    input  logic [P_W-1:0]      dsp_p,
    input  logic                dsp_carry_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_W-1:0]      out_p,
    output logic                out_carry_out,
    output logic [TAG_W-1:0]    out_tag
);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int FIFO_W = P_W + 1 + TAG_W;

    if (DEPTH < DSP_LAT + 1) begin : g_depth_check
        $error("DEPTH must be at least DSP_LAT+1");
    end

    logic                fire;
    logic                pop;
    logic [OCC_W-1:0]    occ;
    logic [TAG_W-1:0]    tag;
    logic [DSP_LAT:0]    tok_valid;
    logic [TAG_W-1:0]    tok_tag [DSP_LAT+1];
    logic                fifo_empty;
    logic                fifo_full;
    logic [FIFO_W-1:0]   fifo_rd_data;

    assign in_ready  = ~dsp_rst & (occ < OCC_W'(DEPTH));
    assign fire      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign dsp_ce    = ~dsp_rst;
    assign out_valid = ~fifo_empty;
    assign {out_p, out_carry_out, out_tag} = fifo_rd_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dsp_rst      <= 1'b1;
            dsp_a        <= '0;
            dsp_b        <= '0;
            dsp_d        <= '0;
            dsp_c        <= '0;
            dsp_opmode   <= '0;
            dsp_carry_in <= 1'b0;
            occ          <= '0;
            tag          <= '0;
        end else begin
            dsp_rst <= 1'b0;
            if (fire) begin
                dsp_a        <= in_a;
                dsp_b        <= in_b;
                dsp_d        <= in_d;
                dsp_c        <= in_c;
                dsp_opmode   <= in_opmode;
                dsp_carry_in <= in_carry_in;
                tag          <= tag + 1'b1;
            end
            case ({fire, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Token stage k holds the op whose operands have been in the slice for k edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tok_valid <= '0;
            for (int i = 0; i <= DSP_LAT; i++) begin
                tok_tag[i] <= '0;
            end
        end else begin
            tok_valid  <= {tok_valid[DSP_LAT-1:0], fire};
            tok_tag[0] <= tag;
            for (int i = 1; i <= DSP_LAT; i++) begin
                tok_tag[i] <= tok_tag[i-1];
            end
        end
    end

    dsp_result_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (tok_valid[DSP_LAT]),
        .wr_data ({dsp_p, dsp_carry_out, tok_tag[DSP_LAT]}),
        .rd_en   (out_ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );
endmodule

// File: tb/tb_dsp48a1_op_sequencer.sv
// tb/tb_dsp48a1_op_sequencer.sv - randomized self-checking bench with behavioural slice and scoreboard
module tb_dsp48a1_op_sequencer;
    import dsp48a1_pkg::*;

    localparam int DSP_LAT = 4;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = 4;
    localparam logic [1:0] Z_C = 2'b11;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [A_W-1:0]      in_a = '0;
    logic [B_W-1:0]      in_b = '0;
    logic [D_W-1:0]      in_d = '0;
    logic [C_W-1:0]      in_c = '0;
    logic [OPMODE_W-1:0] in_opmode = '0;
    logic                in_carry_in = 1'b0;
    logic [A_W-1:0]      dsp_a;
    logic [B_W-1:0]      dsp_b;
    logic [D_W-1:0]      dsp_d;
    logic [C_W-1:0]      dsp_c;
    logic [OPMODE_W-1:0] dsp_opmode;
    logic                dsp_carry_in;
    logic                dsp_ce;
    logic                dsp_rst;
    logic [P_W-1:0]      dsp_p;
    logic                dsp_carry_out;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [P_W-1:0]      out_p;
    logic                out_carry_out;
    logic [TAG_W-1:0]    out_tag;

    always #5 CLK = ~CLK;

    dsp48a1_op_sequencer #(.DSP_LAT(DSP_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_c(in_c),
        .in_opmode(in_opmode), .in_carry_in(in_carry_in),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_carry_in(dsp_carry_in),
        .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p), .dsp_carry_out(dsp_carry_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_carry_out(out_carry_out), .out_tag(out_tag)
    );

    // Arithmetic of the slice for the OPMODE subset this bench drives: {carry_out, P}
    function automatic logic [48:0] slice_math(input logic [17:0] a, input logic [17:0] b,
                                               input logic [47:0] c, input logic [17:0] d,
                                               input logic [7:0] op, input logic cin);
        logic [17:0] pre;
        logic [35:0] m;
        logic [47:0] x;
        logic [47:0] z;
        pre = b;
        if (op[PREADD_EN_BIT]) pre = op[PRESUB_BIT] ? d - b : d + b;
        m = pre * a;
        x = (op[1:0] == X_M) ? {12'b0, m} : 48'b0;
        z = (op[3:2] == Z_C) ? c : 48'b0;
        return {1'b0, x} + {1'b0, z} + {48'b0, cin};
    endfunction

    // Four-register slice stand-in: pins -> s1 -> s2 -> s3 -> P
    logic [48:0] s1, s2, s3, s4;
    always @(posedge CLK) begin
        if (dsp_rst) begin
            s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
        end else if (dsp_ce) begin
            s1 <= slice_math(dsp_a, dsp_b, dsp_c, dsp_d, dsp_opmode, dsp_carry_in);
            s2 <= s1; s3 <= s2; s4 <= s3;
        end
    end
    assign dsp_p         = s4[47:0];
    assign dsp_carry_out = s4[48];

    typedef struct {
        logic [48:0]      res;
        logic [TAG_W-1:0] tag;
        int               rdy;
    } exp_t;

    exp_t             exp_q[$];
    int               n_chk  = 0;
    int               n_pass = 0;
    int               cyc    = 0;
    int               n_acc  = 0;
    int               n_pop  = 0;
    logic [TAG_W-1:0] tag_ctr = '0;
    bit               up = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic rnd_op();
        in_a        = 18'($urandom);
        in_b        = 18'($urandom);
        in_d        = 18'($urandom);
        in_c        = {16'($urandom), 32'($urandom)};
        in_opmode   = {1'b0, 1'($urandom), 1'b0, 1'($urandom),
                       ($urandom_range(1) != 0) ? Z_C : Z_ZERO,
                       ($urandom_range(1) != 0) ? X_M : 2'b00};
        in_carry_in = 1'($urandom);
    endtask

    // One clock: check handshake state, score pop/fire, advance to next sample point
    task automatic step();
        bit fire, pop, rst_now;
        exp_t e;
        fire = in_valid && in_ready;
        pop  = out_valid && out_ready;
        check("in_ready", in_ready, up && (exp_q.size() < DEPTH));
        check("out_valid", out_valid, (exp_q.size() > 0) && (cyc >= exp_q[0].rdy));
        if (pop && exp_q.size() > 0) begin
            check("out_p", out_p, exp_q[0].res[47:0]);
            check("out_carry_out", out_carry_out, exp_q[0].res[48]);
            check("out_tag", out_tag, exp_q[0].tag);
            void'(exp_q.pop_front());
            n_pop++;
        end
        if (fire) begin
            e.res = slice_math(in_a, in_b, in_c, in_d, in_opmode, in_carry_in);
            e.tag = tag_ctr;
            e.rdy = cyc + DSP_LAT + 2;
            exp_q.push_back(e);
            tag_ctr++;
            n_acc++;
        end
        rst_now = RST;
        @(posedge CLK);
        #1;
        cyc++;
        if (!rst_now) up = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        RST      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_dsp_rst", dsp_rst, 1);
        exp_q.delete();
        tag_ctr = '0;
        up      = 1'b0;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("rst_hold_dsp_ce", dsp_ce, 0);
        RST = 1'b0;
        #1;
        check("rel_dsp_rst", dsp_rst, 1);
        check("rel_in_ready", in_ready, 0);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        step();
        check("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        int k0, a0, p0, n;

        @(posedge CLK);
        #1;
        // 1: reset and release
        do_reset(3);
        step();
        check("t1_dsp_rst", dsp_rst, 0);
        check("t1_dsp_ce", dsp_ce, 1);
        check("t1_in_ready", in_ready, 1);
        check("t1_out_valid", out_valid, 0);

        // 2: single op, minimum latency
        in_a = 18'd3; in_b = 18'd5; in_c = '0; in_d = '0; in_opmode = 8'h01; in_carry_in = 1'b0;
        in_valid = 1'b1;
        k0 = cyc;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("t2_latency", cyc - k0, DSP_LAT + 2);
        check("t2_p", out_p, 15);
        check("t2_tag", out_tag, 0);
        drain();

        // 3: eight back-to-back ops, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rnd_op();
            in_valid = 1'b1;
            step();
        end
        drain();

        // 4: consumer stalled, sequencer stops at DEPTH
        out_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 20; i++) begin
            rnd_op();
            in_valid = 1'b1;
            step();
        end
        check("t4_accepted", n_acc - a0, DEPTH);
        check("t4_in_ready", in_ready, 0);
        p0 = n_pop;
        drain();
        check("t4_popped", n_pop - p0, DEPTH);

        // 5: occ=7 with simultaneous fire and pop
        out_ready = 1'b0;
        a0 = n_acc;
        n = 0;
        while (n_acc - a0 < 7 && n < 20) begin rnd_op(); in_valid = 1'b1; step(); n++; end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        rnd_op();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("t5_in_ready", in_ready, 1);
        // 5b: fill to 8, then one pop reopens
        out_ready = 1'b0;
        step();
        check("t5b_full", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("t5b_reopen", in_ready, 1);
        drain();

        // 6: reset with 3 in flight and 2 queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin rnd_op(); in_valid = 1'b1; step(); end
        in_valid = 1'b0;
        step();
        step();
        check("t6_out_valid_pre", out_valid, 1);
        do_reset(1);
        step();
        rnd_op();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("t6_tag", out_tag, 0);
        drain();

        // 6b: tag wrap across 17 consecutive ops
        do_reset(2);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin rnd_op(); in_valid = 1'b1; step(); end
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_op();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
